// File: rtl/adc_pkg.sv
// Shared ADC serial-port definitions: word/tag widths, tagged sample type and
// deframer FSM state encoding.
package adc_pkg;

  localparam int ADC_WORD_W   = 16;
  localparam int ADC_CHAN_W   = 3;
  localparam int ADC_NUM_REGS = 8;

  typedef struct packed {
    logic [ADC_CHAN_W-1:0] chan;
    logic [ADC_WORD_W-1:0] sample;
  } adc_sample_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_FS = 2'd1,
    ST_SHIFT   = 2'd2
  } adc_state_t;

  // Channel tag advance with wrap after the last channel of a frame.
  function automatic logic [ADC_CHAN_W-1:0] chan_next(input logic [ADC_CHAN_W-1:0] c,
                                                      input int n);
    return (int'(c) == n - 1) ? '0 : c + ADC_CHAN_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, level count and full/empty.
// A push while full is accepted only when a pop frees a slot on the same edge.
module sync_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 8
) (
  input  logic                   SCLK,
  input  logic                   rst_l,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_rd;
  logic             do_wr;

  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);
  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end
      rd_valid <= do_rd;
      level    <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

  always_ff @(posedge SCLK) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/adc_sample_deframer.sv
// Deserializes SDOFS-framed ADC words from SDO, tags each with its channel
// index and queues the tagged words in a FIFO for the acquisition logic.
module adc_sample_deframer
  import adc_pkg::*;
#(
  parameter int CHANNELS   = 6,
  parameter int WORD_W     = ADC_WORD_W,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         SCLK,
  input  logic                         rst_l,
  input  logic                         enable,
  input  logic                         SDOFS,
  input  logic                         SDO,
  input  logic                         chan_rst,
  input  logic                         rd_en,
  output logic [ADC_CHAN_W+WORD_W-1:0] dout,
  output logic                         dout_valid,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  level,
  output logic                         overflow,
  output logic                         frame_err,
  input  logic                         clr_err
);

  localparam int BIT_W = $clog2(WORD_W);

  adc_state_t              state;
  adc_state_t              state_nxt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [WORD_W-2:0]       shreg;
  logic [ADC_CHAN_W-1:0]   chan;
  logic                    in_shift;
  logic                    start;
  logic                    word_done;
  logic                    fs_err;
  logic                    shift_en;
  logic                    ovf_set;

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT_FS: state_nxt = SDOFS ? ST_SHIFT : ST_WAIT_FS;
        ST_SHIFT:            if (word_done && !SDOFS) state_nxt = ST_WAIT_FS;
        default:             state_nxt = ST_IDLE;
      endcase
    end
  end

  // An SDOFS on the LSB edge chains the next frame rather than flagging an error.
  always_comb begin
    in_shift  = enable && (state == ST_SHIFT);
    start     = enable && (state != ST_SHIFT) && SDOFS;
    word_done = in_shift && (bit_cnt == BIT_W'(WORD_W - 1));
    fs_err    = in_shift && SDOFS && !word_done;
    shift_en  = in_shift && !fs_err;
  end

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      bit_cnt <= '0;
      shreg   <= '0;
      chan    <= '0;
    end else if (!enable) begin
      bit_cnt <= '0;
      shreg   <= '0;
      chan    <= '0;
    end else begin
      if (start || fs_err || word_done) bit_cnt <= '0;
      else if (shift_en)                bit_cnt <= bit_cnt + BIT_W'(1);

      if (fs_err)        shreg <= '0;
      else if (shift_en) shreg <= {shreg[WORD_W-3:0], SDO};

      // The word being pushed keeps its tag; chan_rst only affects the next one.
      if (word_done)     chan <= chan_rst ? '0 : chan_next(chan, CHANNELS);
      else if (chan_rst) chan <= '0;
    end
  end

  // Full implies non-empty, so a pop on this edge always frees a slot.
  assign ovf_set = word_done && full && !rd_en;

  always_ff @(posedge SCLK or negedge rst_l) begin
    if (!rst_l) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (fs_err)       frame_err <= 1'b1;
      else if (clr_err) frame_err <= 1'b0;
    end
  end

  sync_fifo #(
    .WIDTH (ADC_CHAN_W + WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .SCLK     (SCLK),
    .rst_l    (rst_l),
    .wr_en    (word_done),
    .wr_data  ({chan, shreg, SDO}),
    .rd_en    (rd_en),
    .rd_data  (dout),
    .rd_valid (dout_valid),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

endmodule

// File: tb/tb_adc_sample_deframer.sv
// Randomized bench for adc_sample_deframer against a queue-based model of the
// tagged-sample stream, FIFO occupancy and sticky error flags.
module tb_adc_sample_deframer;

  localparam int CHANNELS   = 6;
  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic SCLK = 1'b0;
  logic rst_l = 1'b0;
  logic enable = 1'b0;
  logic SDOFS = 1'b0;
  logic SDO = 1'b0;
  logic chan_rst = 1'b0;
  logic rd_en = 1'b0;
  logic clr_err = 1'b0;
  logic [3+WORD_W-1:0] dout;
  logic                dout_valid;
  logic                empty;
  logic                full;
  logic [LVL_W-1:0]    level;
  logic                overflow;
  logic                frame_err;

  int compare_cnt = 0;
  int mismatch_cnt = 0;

  logic [3+WORD_W-1:0] exp_q[$];
  logic [3+WORD_W-1:0] exp_dout;
  int                  exp_chan;
  bit                  exp_ovf;
  bit                  exp_ferr;

  adc_sample_deframer #(
    .CHANNELS   (CHANNELS),
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .SCLK       (SCLK),
    .rst_l      (rst_l),
    .enable     (enable),
    .SDOFS      (SDOFS),
    .SDO        (SDO),
    .chan_rst   (chan_rst),
    .rd_en      (rd_en),
    .dout       (dout),
    .dout_valid (dout_valid),
    .empty      (empty),
    .full       (full),
    .level      (level),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  always #5 SCLK = ~SCLK;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compare_cnt++;
    if (got !== exp) begin
      mismatch_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    exp_q.delete();
    exp_dout = '0;
    exp_chan = 0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic checkAll(input bit exp_valid);
    checkOutput("dout_valid", 32'(dout_valid), 32'(exp_valid));
    checkOutput("dout", 32'(dout), 32'(exp_dout));
    checkOutput("level", 32'(level), 32'(exp_q.size()));
    checkOutput("empty", 32'(empty), 32'(exp_q.size() == 0));
    checkOutput("full", 32'(full), 32'(exp_q.size() == FIFO_DEPTH));
    checkOutput("overflow", 32'(overflow), 32'(exp_ovf));
    checkOutput("frame_err", 32'(frame_err), 32'(exp_ferr));
  endtask

  // One SCLK cycle: drive inputs, let the rising edge pass, update the model, check.
  task automatic applyStimulus(input bit fs, input bit sdo, input bit rd, input bit crst,
                               input bit clr, input bit push, input logic [WORD_W-1:0] word,
                               input bit ferr);
    bit valid;
    SDOFS    = fs;
    SDO      = sdo;
    rd_en    = rd;
    chan_rst = crst;
    clr_err  = clr;
    @(negedge SCLK);
    valid = 1'b0;
    if (clr) begin
      exp_ovf  = 1'b0;
      exp_ferr = 1'b0;
    end
    if (rd && exp_q.size() > 0) begin
      exp_dout = exp_q.pop_front();
      valid    = 1'b1;
    end
    if (push) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back({3'(exp_chan), word});
      else                           exp_ovf = 1'b1;
      exp_chan = (exp_chan + 1) % CHANNELS;
    end
    if (crst) exp_chan = 0;
    if (ferr) exp_ferr = 1'b1;
    if (!enable) exp_chan = 0;
    checkAll(valid);
  endtask

  task automatic sendWord(input logic [WORD_W-1:0] w, input bit with_fs, input bit chain,
                          input bit rd_lsb, input bit crst_lsb);
    if (with_fs) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = WORD_W - 1; i >= 0; i--) begin
      applyStimulus((i == 0) && chain, w[i], (i == 0) && rd_lsb, (i == 0) && crst_lsb,
                    1'b0, i == 0, w, 1'b0);
    end
  endtask

  task automatic idle(input int n, input bit rand_rd);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'($urandom), rand_rd && ($urandom_range(0, 1) == 1),
                    1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic clearErrors();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    compare_cnt++;
    mismatch_cnt++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

  initial begin
    bit chained;
    bit nxt;
    modelReset();
    @(negedge SCLK);
    checkAll(1'b0);
    rst_l  = 1'b1;
    enable = 1'b1;
    idle(2, 1'b0);

    // Back-to-back frames with fixed samples, tags 0..5.
    for (int k = 0; k < 6; k++) sendWord(16'(16'h1111 * (k + 1)), k == 0, k < 5, 1'b0, 1'b0);
    drain();

    // Gapped frames; the seventh wraps to tag 0.
    for (int k = 0; k < 7; k++) begin
      sendWord(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
      idle(3, 1'b0);
    end
    drain();

    // SDOFS after nine bits discards the partial word and flags the error.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
    sendWord(16'hA5C3, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0);
    clearErrors();
    drain();

    // Nine words without reads: the ninth is dropped.
    for (int k = 0; k < 9; k++) sendWord(16'($urandom), k == 0, k < 8, 1'b0, 1'b0);
    idle(2, 1'b0);
    drain();
    clearErrors();

    // Push and pop on the same edge while full.
    for (int k = 0; k < 8; k++) sendWord(16'($urandom), k == 0, k < 7, 1'b0, 1'b0);
    idle(1, 1'b0);
    sendWord(16'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
    drain();

    // Asynchronous reset during bit 7 of a word with data queued.
    sendWord(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    SDOFS = 1'b0;
    #2;
    rst_l = 1'b0;
    #1;
    modelReset();
    checkAll(1'b0);
    @(negedge SCLK);
    rst_l = 1'b1;
    idle(2, 1'b0);

    // chan_rst coincident with a push: old tag kept, next word tagged 0.
    sendWord(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    sendWord(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);
    sendWord(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Dropping enable restarts the channel count.
    sendWord(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    enable = 1'b0;
    idle(2, 1'b0);
    enable = 1'b1;
    idle(1, 1'b0);
    sendWord(16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Random frames, chaining, gaps and reads.
    chained = 1'b0;
    for (int it = 0; it < 40; it++) begin
      nxt = (it < 39) && ($urandom_range(0, 2) == 0);
      sendWord(16'($urandom), !chained, nxt, $urandom_range(0, 1) == 1, 1'b0);
      if (!nxt) idle($urandom_range(0, 4), 1'b1);
      chained = nxt;
    end
    drain();
    clearErrors();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
    $finish;
  end

endmodule
